// File: rtl/hex_disp_scan.sv
// hex_disp_scan: time-multiplexes a 16-bit value as four hex digits onto a
// common-anode 4-digit seven-segment display. It also latches the counter's
// ripple carry into a sticky overflow LED.
// Optional feature: define HEX_DISP_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module hex_disp_scan #(
   parameter int SCAN_DIV_W = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic        rc,
   input  logic [3:0]  dp_in,
   input  logic        clr_ovf,
   output logic [3:0]  an,
   output logic [7:0]  seg,
   output logic        ovf_led
);

   logic [SCAN_DIV_W-1:0] prescaler_reg;
   logic [1:0]            idx_reg;
   logic [15:0]           snap_reg;
   logic [3:0]            snap_dp_reg;
   logic [3:0]            an_reg;
   logic [7:0]            seg_reg;
   logic                  ovf_reg;

   logic                  tick;
   logic [3:0]            nibbles [4];
   logic [3:0]            an_next;
   logic [7:0]            seg_next;

   // Each digit slot ends when the prescaler reaches all-ones.
   assign tick = &prescaler_reg;

   // Split the snapshot into per-digit nibbles.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_nib
         assign nibbles[gi] = snap_reg[4*gi +: 4];
      end
   endgenerate

`ifdef HEX_DISP_LEADING_ZERO_BLANK_EN
   // A digit is blanked when it and every higher nibble are zero.
   // Digit 0 is always shown.
   logic [3:0] blank;
   assign blank[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < 4; gi++) begin : g_blank
         assign blank[gi] = (snap_reg[15:4*gi] == '0);
      end
   endgenerate
`endif

   // Hex to segments a..g (active-low). Bit 6 is g and bit 0 is a.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Next display pattern, derived from the current digit index and the snapshot.
   always_comb begin
      an_next          = 4'b1111;
      an_next[idx_reg] = 1'b0;
      seg_next         = {~snap_dp_reg[idx_reg], hex7(nibbles[idx_reg])};
`ifdef HEX_DISP_LEADING_ZERO_BLANK_EN
      if (blank[idx_reg]) begin
         an_next  = 4'b1111;
         seg_next = 8'hFF;
      end
`endif
   end

   // Scan timing, the snapshot taken at the 3->0 wrap, registered outputs, and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler_reg <= '0;
         idx_reg       <= 2'd0;
         snap_reg      <= 16'h0000;
         snap_dp_reg   <= 4'h0;
         an_reg        <= 4'b1111;
         seg_reg       <= 8'hFF;
         ovf_reg       <= 1'b0;
      end else begin
         prescaler_reg <= prescaler_reg + {{(SCAN_DIV_W-1){1'b0}}, 1'b1};
         if (tick) begin
            idx_reg <= idx_reg + 2'd1;
            // Capture at the end of digit 3 so that a whole scan shows one coherent value.
            if (idx_reg == 2'd3) begin
               snap_reg    <= value;
               snap_dp_reg <= dp_in;
            end
         end
         an_reg  <= an_next;
         seg_reg <= seg_next;
         // Set takes priority over clear, so a carry is never lost.
         if (rc)
            ovf_reg <= 1'b1;
         else if (clr_ovf)
            ovf_reg <= 1'b0;
      end
   end

   assign an      = an_reg;
   assign seg     = seg_reg;
   assign ovf_led = ovf_reg;

endmodule

// File: tb/tb_hex_disp_scan.sv
// tb_hex_disp_scan: directed scoreboard bench for hex_disp_scan with SCAN_DIV_W=2.
// A digit slot lasts 4 cycles and a full scan lasts 16 cycles.
// Expected display states are queued per cycle, and a negedge monitor checks them.
module tb_hex_disp_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] value;
   logic        rc;
   logic [3:0]  dp_in;
   logic        clr_ovf;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic        ovf_led;

   int cyc = 0;
   int tests = 0;
   int fails = 0;

   typedef struct {
      int         cyc;
      bit         kind;   // 0: an/seg, 1: ovf_led
      logic [3:0] an;
      logic [7:0] seg;
      logic       ovf;
      string      name;
   } exp_t;

   exp_t sb[$];

   hex_disp_scan #(.SCAN_DIV_W(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .value   (value),
      .rc      (rc),
      .dp_in   (dp_in),
      .clr_ovf (clr_ovf),
      .an      (an),
      .seg     (seg),
      .ovf_led (ovf_led)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic exp_vis(input int c, input logic [3:0] a, input logic [7:0] s, input string n);
      exp_t e;
      e.cyc = c; e.kind = 1'b0; e.an = a; e.seg = s; e.ovf = 1'b0; e.name = n;
      sb.push_back(e);
   endtask

   task automatic exp_slot(input int c, input logic [3:0] a, input logic [7:0] s, input string n);
      for (int i = 0; i < 4; i++) exp_vis(c + i, a, s, n);
   endtask

   // Slot for a digit that the blanking option turns off (a leading zero).
   task automatic exp_lead(input int c, input logic [3:0] a, input logic [7:0] s, input string n);
`ifdef HEX_DISP_LEADING_ZERO_BLANK_EN
      exp_slot(c, 4'b1111, 8'hFF, n);
`else
      exp_slot(c, a, s, n);
`endif
   endtask

   task automatic exp_ovf(input int c0, input int c1, input logic v, input string n);
      exp_t e;
      for (int c = c0; c <= c1; c++) begin
         e.cyc = c; e.kind = 1'b1; e.an = 4'h0; e.seg = 8'h00; e.ovf = v; e.name = n;
         sb.push_back(e);
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc != n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: check every queued expectation that is due this cycle.
   always @(negedge clk) begin
      int i;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].cyc == cyc) begin
            tests++;
            if (sb[i].kind == 1'b0) begin
               if (an !== sb[i].an || seg !== sb[i].seg) begin
                  fails++;
                  $display("FAIL %s cyc=%0d an=%b seg=%h expected an=%b seg=%h",
                           sb[i].name, cyc, an, seg, sb[i].an, sb[i].seg);
               end else
                  $display("[TB] ok %s cyc=%0d an=%b seg=%h", sb[i].name, cyc, an, seg);
            end else begin
               if (ovf_led !== sb[i].ovf) begin
                  fails++;
                  $display("FAIL %s cyc=%0d ovf_led=%b expected %b",
                           sb[i].name, cyc, ovf_led, sb[i].ovf);
               end else
                  $display("[TB] ok %s cyc=%0d ovf_led=%b", sb[i].name, cyc, ovf_led);
            end
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            tests++;
            fails++;
            $display("FAIL %s missed check for cyc=%0d", sb[i].name, sb[i].cyc);
            sb.delete(i);
         end else
            i++;
      end
   end

   initial begin
      rst = 1'b1; value = 16'h1234; dp_in = 4'h0; rc = 1'b0; clr_ovf = 1'b0;

      // Reset is held for edges 1..3, and release comes after edge 3.
      for (int c = 1; c <= 3; c++) exp_vis(c, 4'b1111, 8'hFF, "reset");
      exp_ovf(1, 3, 1'b0, "reset_ovf");
      // Scan 0 shows snap=0.
      exp_slot(4,  4'b1110, 8'hC0, "scan0_d0");
      exp_lead(8,  4'b1101, 8'hC0, "scan0_d1");
      exp_lead(12, 4'b1011, 8'hC0, "scan0_d2");
      exp_lead(16, 4'b0111, 8'hC0, "scan0_d3");
      // Overflow timeline.
      exp_ovf(4, 5, 1'b0, "ovf_idle");
      exp_ovf(6, 105, 1'b1, "ovf_held");
      exp_ovf(106, 106, 1'b0, "ovf_clr");
      exp_ovf(107, 108, 1'b1, "ovf_set_wins");
      exp_ovf(109, 110, 1'b0, "ovf_rst");
      wait_cyc(3);
      rst = 1'b0;

      // Scan 1 shows 1234.
      exp_slot(20, 4'b1110, 8'h99, "scan1_d0");
      exp_slot(24, 4'b1101, 8'hB0, "scan1_d1");
      exp_slot(28, 4'b1011, 8'hA4, "scan1_d2");
      exp_slot(32, 4'b0111, 8'hF9, "scan1_d3");
      // Scan 2: the value changes during digit 1, but the display shows no tearing.
      exp_slot(36, 4'b1110, 8'h99, "scan2_d0");
      exp_slot(40, 4'b1101, 8'hB0, "scan2_d1");
      exp_slot(44, 4'b1011, 8'hA4, "coher_d2");
      exp_slot(48, 4'b0111, 8'hF9, "coher_d3");
      // Scan 3 shows ABCD.
      exp_slot(52, 4'b1110, 8'hA1, "abcd_d0");
      exp_slot(56, 4'b1101, 8'hC6, "abcd_d1");
      exp_slot(60, 4'b1011, 8'h83, "abcd_d2");
      exp_slot(64, 4'b0111, 8'h88, "abcd_d3");

      wait_cyc(5);
      rc = 1'b1;
      wait_cyc(6);
      rc = 1'b0;

      wait_cyc(41);
      value = 16'hABCD;

      // Decimal point on digit 2, with value 0000.
      wait_cyc(63);
      value = 16'h0000; dp_in = 4'b0100;
      exp_slot(68, 4'b1110, 8'hC0, "dp_d0");
      exp_lead(72, 4'b1101, 8'hC0, "dp_d1");
      exp_lead(76, 4'b1011, 8'h40, "dp_d2");
      exp_lead(80, 4'b0111, 8'hC0, "dp_d3");

      // Value 0005.
      wait_cyc(79);
      value = 16'h0005; dp_in = 4'h0;
      exp_slot(84, 4'b1110, 8'h92, "v5_d0");
      exp_lead(88, 4'b1101, 8'hC0, "v5_d1");
      exp_lead(92, 4'b1011, 8'hC0, "v5_d2");
      exp_lead(96, 4'b0111, 8'hC0, "v5_d3");

      // Value 0100; a reset interrupts this scan during digit 2.
      wait_cyc(95);
      value = 16'h0100;
      exp_slot(100, 4'b1110, 8'hC0, "v100_d0");
      exp_slot(104, 4'b1101, 8'hC0, "v100_d1");
      exp_vis(108, 4'b1011, 8'hF9, "v100_d2");

      wait_cyc(105);
      clr_ovf = 1'b1;
      wait_cyc(106);
      rc = 1'b1;
      wait_cyc(107);
      rc = 1'b0; clr_ovf = 1'b0;

      wait_cyc(108);
      rst = 1'b1;
      exp_vis(109, 4'b1111, 8'hFF, "midrst");
      exp_slot(110, 4'b1110, 8'hC0, "postrst_d0");
      exp_lead(114, 4'b1101, 8'hC0, "postrst_d1");
      wait_cyc(109);
      rst = 1'b0;

      wait_cyc(120);
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL leftover %0d expectations were left unchecked, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
